// File: rtl/rf_hazard_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rf_hazard_ctrl_if                                                     |
// | Issue, forwarding and RF write-port bundle for the hazard controller. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface rf_hazard_ctrl_if #(
  parameter int WORD_SIZE     = 16,
  parameter int REG_ADDR_BITS = 2,
  parameter int CNT_BITS      = 16
);
  logic                     issue_valid;
  logic                     issue_use1;
  logic [REG_ADDR_BITS-1:0] issue_rs1;
  logic                     issue_use2;
  logic [REG_ADDR_BITS-1:0] issue_rs2;
  logic                     issue_wr;
  logic [REG_ADDR_BITS-1:0] issue_rd;
  logic                     issue_load;
  logic [WORD_SIZE-1:0]     ex_result;
  logic [WORD_SIZE-1:0]     mem_rdata;
  logic [WORD_SIZE-1:0]     rf_data1;
  logic [WORD_SIZE-1:0]     rf_data2;
  logic                     mem_busy;
  logic                     flush;
  logic                     stall;
  logic [WORD_SIZE-1:0]     opnd1;
  logic [WORD_SIZE-1:0]     opnd2;
  logic [1:0]               fwd_sel1;
  logic [1:0]               fwd_sel2;
  logic                     rf_write;
  logic [REG_ADDR_BITS-1:0] rf_waddr;
  logic [WORD_SIZE-1:0]     rf_wdata;
  logic [CNT_BITS-1:0]      stall_cnt;

  modport master (
    output issue_valid, issue_use1, issue_rs1, issue_use2, issue_rs2,
           issue_wr, issue_rd, issue_load, ex_result, mem_rdata,
           rf_data1, rf_data2, mem_busy, flush,
    input  stall, opnd1, opnd2, fwd_sel1, fwd_sel2,
           rf_write, rf_waddr, rf_wdata, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_use1, issue_rs1, issue_use2, issue_rs2,
           issue_wr, issue_rd, issue_load, ex_result, mem_rdata,
           rf_data1, rf_data2, mem_busy, flush,
    output stall, opnd1, opnd2, fwd_sel1, fwd_sel2,
           rf_write, rf_waddr, rf_wdata, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rf_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rf_hazard_ctrl                                                        |
// | EX/MEM/WB destination tracking, operand forwarding, load-use stall.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rf_hazard_ctrl #(
  parameter int WORD_SIZE     = 16,
  parameter int REG_ADDR_BITS = 2,
  parameter int CNT_BITS      = 16
) (
  input  wire logic        clk,
  input  wire logic        reset,
  rf_hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic                     valid;
    logic                     wr;
    logic [REG_ADDR_BITS-1:0] rd;
  } slot_t;

  slot_t                ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic                 ex_load_q, ex_load_d, mem_load_q, mem_load_d;
  logic [WORD_SIZE-1:0] mem_data_q, mem_data_d, wb_data_q, wb_data_d;
  logic [CNT_BITS-1:0]  stall_cnt_q, stall_cnt_d;

  logic [WORD_SIZE-1:0]     mem_fwd_data;
  logic                     stall;
  logic                     use_v     [2];
  logic [REG_ADDR_BITS-1:0] rs_v      [2];
  logic [WORD_SIZE-1:0]     rf_v      [2];
  logic [WORD_SIZE-1:0]     opnd_v    [2];
  logic [1:0]               sel_v     [2];
  logic                     ex_ld_hit [2];

  function automatic logic hit(input slot_t s, input logic use_rs,
                               input logic [REG_ADDR_BITS-1:0] rs);
    return s.valid && s.wr && use_rs && (s.rd == rs);
  endfunction

  // A load in MEM has no result in mem_data_q yet; its value is on mem_rdata.
  assign mem_fwd_data = mem_load_q ? bus.mem_rdata : mem_data_q;

  assign use_v[0] = bus.issue_use1;
  assign use_v[1] = bus.issue_use2;
  assign rs_v[0]  = bus.issue_rs1;
  assign rs_v[1]  = bus.issue_rs2;
  assign rf_v[0]  = bus.rf_data1;
  assign rf_v[1]  = bus.rf_data2;

  for (genvar i = 0; i < 2; i++) begin : g_opnd
    always_comb begin
      sel_v[i]     = 2'd0;
      opnd_v[i]    = rf_v[i];
      ex_ld_hit[i] = 1'b0;
      if (!reset) begin
        ex_ld_hit[i] = hit(ex_q, use_v[i], rs_v[i]) && ex_load_q;
        if (hit(ex_q, use_v[i], rs_v[i]) && !ex_load_q) begin
          sel_v[i]  = 2'd1;
          opnd_v[i] = bus.ex_result;
        end else if (hit(mem_q, use_v[i], rs_v[i])) begin
          sel_v[i]  = 2'd2;
          opnd_v[i] = mem_fwd_data;
        end else if (hit(wb_q, use_v[i], rs_v[i])) begin
          sel_v[i]  = 2'd3;
          opnd_v[i] = wb_data_q;
        end
      end
    end
  end

  assign stall = !reset && bus.issue_valid && (ex_ld_hit[0] || ex_ld_hit[1]);

  assign bus.stall     = stall;
  assign bus.fwd_sel1  = sel_v[0];
  assign bus.fwd_sel2  = sel_v[1];
  assign bus.opnd1     = opnd_v[0];
  assign bus.opnd2     = opnd_v[1];
  assign bus.rf_write  = !reset && wb_q.valid && wb_q.wr;
  assign bus.rf_waddr  = wb_q.rd;
  assign bus.rf_wdata  = wb_data_q;
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    ex_d        = ex_q;
    ex_load_d   = ex_load_q;
    mem_d       = mem_q;
    mem_load_d  = mem_load_q;
    mem_data_d  = mem_data_q;
    wb_d        = wb_q;
    wb_data_d   = wb_data_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.mem_busy) begin
      wb_d       = mem_q;
      wb_data_d  = mem_fwd_data;
      mem_d      = ex_q;
      mem_load_d = ex_load_q;
      mem_data_d = bus.ex_result;
      if (bus.flush) begin
        mem_d.valid = 1'b0;
      end
      ex_d.valid = bus.issue_valid && !stall && !bus.flush;
      ex_d.wr    = bus.issue_wr;
      ex_d.rd    = bus.issue_rd;
      ex_load_d  = bus.issue_load;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
      end
    end else if (bus.flush) begin
      // Frozen pipeline: only the EX instruction can be killed in place.
      ex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      ex_load_q   <= 1'b0;
      mem_q       <= '0;
      mem_load_q  <= 1'b0;
      mem_data_q  <= '0;
      wb_q        <= '0;
      wb_data_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_load_q   <= ex_load_d;
      mem_q       <= mem_d;
      mem_load_q  <= mem_load_d;
      mem_data_q  <= mem_data_d;
      wb_q        <= wb_d;
      wb_data_q   <= wb_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_rf_hazard_ctrl                                                     |
// | Directed stimulus with queued expectations checked by a monitor.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_rf_hazard_ctrl;
  // Narrow counter so saturation is reachable: a stall always leaves a bubble
  // in EX, so at most every other cycle can stall.
  localparam int CNT_BITS = 10;
  localparam logic [15:0] RF1 = 16'hA001;
  localparam logic [15:0] RF2 = 16'hA002;

  typedef struct packed {
    logic        stall;
    logic [1:0]  s1;
    logic [15:0] o1;
    logic [1:0]  s2;
    logic [15:0] o2;
  } id_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic adv_last = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_id    = 0;
  id_t          id_q [$];
  logic [17:0]  wr_q [$];

  rf_hazard_ctrl_if #(.WORD_SIZE(16), .REG_ADDR_BITS(2), .CNT_BITS(CNT_BITS)) bus ();

  rf_hazard_ctrl #(.WORD_SIZE(16), .REG_ADDR_BITS(2), .CNT_BITS(CNT_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic u1, input logic [1:0] r1,
                           input logic u2, input logic [1:0] r2, input logic wr,
                           input logic [1:0] rd, input logic ld);
    bus.issue_valid = v;
    bus.issue_use1  = u1;
    bus.issue_rs1   = r1;
    bus.issue_use2  = u2;
    bus.issue_rs2   = r2;
    bus.issue_wr    = wr;
    bus.issue_rd    = rd;
    bus.issue_load  = ld;
  endtask

  task automatic exp_id(input logic st, input logic [1:0] s1, input logic [15:0] o1,
                        input logic [1:0] s2, input logic [15:0] o2);
    id_q.push_back('{stall: st, s1: s1, o1: o1, s2: s2, o2: o2});
  endtask

  task automatic exp_wr(input logic [1:0] a, input logic [15:0] d);
    wr_q.push_back({a, d});
  endtask

  task automatic nop();
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
  endtask

  // A write is new only if WB actually advanced on the previous edge.
  always @(posedge clk) adv_last <= !reset && !bus.mem_busy;

  always @(negedge clk) begin
    if (bus.issue_valid) begin
      n_id++;
      if (id_q.size() == 0) begin
        check($sformatf("id#%0d underflow", n_id), 1, 0);
      end else begin
        id_t e;
        e = id_q.pop_front();
        check($sformatf("id#%0d {stall,sel1,opnd1,sel2,opnd2}", n_id),
              longint'({bus.stall, bus.fwd_sel1, bus.opnd1, bus.fwd_sel2, bus.opnd2}),
              longint'(e));
      end
    end
    if (bus.rf_write && adv_last) begin
      if (wr_q.size() == 0) begin
        check("unexpected rf_write {addr,data}", longint'({bus.rf_waddr, bus.rf_wdata}), 0);
      end else begin
        logic [17:0] w;
        w = wr_q.pop_front();
        check("rf_write {addr,data}", longint'({bus.rf_waddr, bus.rf_wdata}), longint'(w));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rf_data1  = RF1;
    bus.rf_data2  = RF2;
    bus.ex_result = 16'h0;
    bus.mem_rdata = 16'h0;
    bus.mem_busy  = 1'b0;
    bus.flush     = 1'b0;
    set_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);

    // Reset state
    tick();
    tick();
    #1;
    check("reset rf_write", bus.rf_write, 0);
    check("reset stall", bus.stall, 0);
    check("reset sel/opnd", longint'({bus.fwd_sel1, bus.opnd1, bus.fwd_sel2, bus.opnd2}),
          longint'({2'd0, RF1, 2'd0, RF2}));
    reset = 1'b0;
    check("reset stall_cnt", bus.stall_cnt, 0);

    // ADD r1 then independent work: write three cycles later
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    exp_wr(2'd1, 16'h1234);
    tick();
    bus.ex_result = 16'h1234; nop(); tick();
    bus.ex_result = 16'hDEAD; nop(); tick();
    nop(); tick();

    // Forwarding distance 1, 2, 3, 4 from ADD r2
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    exp_wr(2'd2, 16'h00AA);
    tick();
    bus.ex_result = 16'h00AA;
    set_issue(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    exp_id(1'b0, 2'd1, 16'h00AA, 2'd0, RF2);
    tick();
    bus.ex_result = 16'hDEAD;
    set_issue(1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd2, 16'h00AA);
    tick();
    set_issue(1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    exp_id(1'b0, 2'd3, 16'h00AA, 2'd3, 16'h00AA);
    tick();
    set_issue(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    tick();

    // Load-use: one stall, then forward of mem_rdata from MEM
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    exp_wr(2'd3, 16'hBEEF);
    tick();
    bus.ex_result = 16'h7777;
    bus.mem_rdata = 16'h0BAD;
    set_issue(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    exp_id(1'b1, 2'd0, RF1, 2'd0, RF2);
    tick();
    check("load-use stall_cnt", bus.stall_cnt, 1);
    bus.mem_rdata = 16'hBEEF;
    exp_id(1'b0, 2'd2, 16'hBEEF, 2'd0, RF2);
    tick();
    bus.mem_rdata = 16'h0BAD;
    bus.mem_busy  = 1'b1;
    nop(); tick();
    check("frozen rf_write {en,addr,data}",
          longint'({bus.rf_write, bus.rf_waddr, bus.rf_wdata}), longint'({1'b1, 2'd3, 16'hBEEF}));
    bus.mem_busy = 1'b0;
    nop(); tick();

    // r1 in EX and MEM: youngest wins
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    exp_wr(2'd1, 16'h2222);
    tick();
    bus.ex_result = 16'h2222;
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    exp_wr(2'd1, 16'h1111);
    tick();
    bus.ex_result = 16'h1111;
    set_issue(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    exp_id(1'b0, 2'd1, 16'h1111, 2'd0, RF2);
    tick();
    bus.ex_result = 16'hDEAD;
    nop(); tick();
    nop(); tick();

    // Flush kills ADD r2 in EX and ADD r0 in ID
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    tick();
    bus.flush = 1'b1;
    bus.ex_result = 16'h5555;
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    tick();
    bus.flush = 1'b0;
    nop(); tick();
    nop(); tick();
    nop(); tick();

    // Flush while frozen: EX cleared, MEM keeps r1
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    exp_wr(2'd1, 16'h3333);
    tick();
    bus.ex_result = 16'h3333;
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    tick();
    bus.ex_result = 16'h4444;
    bus.mem_busy  = 1'b1;
    bus.flush     = 1'b1;
    set_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    tick();
    bus.flush = 1'b0;
    set_issue(1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    exp_id(1'b0, 2'd2, 16'h3333, 2'd0, RF2);
    #1;
    check("frozen flush rf_write", bus.rf_write, 0);
    tick();
    bus.mem_busy = 1'b0;
    set_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    tick();
    nop(); tick();
    nop(); tick();
    nop(); tick();

    // Saturate the stall counter with alternating load / dependent use
    bus.mem_rdata = 16'h0BAD;
    for (int k = 0; k < (1 << CNT_BITS) + 5; k++) begin
      set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1);
      exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
      exp_wr(2'd3, 16'h0BAD);
      tick();
      set_issue(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      if (k == 0) exp_id(1'b1, 2'd0, RF1, 2'd0, RF2);
      else        exp_id(1'b1, 2'd3, 16'h0BAD, 2'd0, RF2);
      tick();
    end
    nop(); tick();
    nop(); tick();
    nop(); tick();
    check("stall_cnt saturated", bus.stall_cnt, (1 << CNT_BITS) - 1);

    // Reset mid-stream wipes in-flight LOAD r1 and ADD r2
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    tick();
    bus.ex_result = 16'h9999;
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    tick();
    reset = 1'b1;
    set_issue(1'b1, 1'b1, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    #1;
    check("mid reset rf_write", bus.rf_write, 0);
    tick();
    reset = 1'b0;
    check("mid reset stall_cnt", bus.stall_cnt, 0);
    exp_id(1'b0, 2'd0, RF1, 2'd0, RF2);
    tick();
    nop(); tick();
    nop(); tick();
    nop(); tick();

    set_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    tick();
    @(negedge clk);
    #1;
    check("id expectations left", id_q.size(), 0);
    check("write expectations left", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_hazard_ctrl.md
Name: rf_hazard_ctrl

Overview:
- Initiator-side companion to the register file in the pipelined TSC CPU.
- Tracks in-flight destination registers in the EX, MEM and WB stages and drives the RF write port from the WB slot.
- For each operand read in ID, selects forwarded data or RF read data.
- Raises a load-use stall and counts stall cycles.

Parameters:
- WORD_SIZE, 16, datapath width.
- REG_ADDR_BITS, 2, register address width (4 GPRs).
- CNT_BITS, 16, width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  instruction in ID requests advance to EX.
- issue_use1  in  1  ID instruction reads rs1.
- issue_rs1  in  REG_ADDR_BITS  source 1 address.
- issue_use2  in  1  ID instruction reads rs2.
- issue_rs2  in  REG_ADDR_BITS  source 2 address.
- issue_wr  in  1  ID instruction writes rd.
- issue_rd  in  REG_ADDR_BITS  destination address.
- issue_load  in  1  ID instruction is a load (data available only after MEM).
- ex_result  in  WORD_SIZE  ALU result of the instruction currently in EX.
- mem_rdata  in  WORD_SIZE  load data of the instruction currently in MEM.
- rf_data1, rf_data2  in  WORD_SIZE  RF read data for issue_rs1/issue_rs2.
- mem_busy  in  1  freezes the whole pipeline.
- flush  in  1  kill the ID and EX instructions (branch mispredict).
- stall  out  1  ID must hold; no issue this cycle.
- opnd1, opnd2  out  WORD_SIZE  resolved operand values for ID.
- fwd_sel1, fwd_sel2  out  2  source of each operand: 0 RF, 1 EX, 2 MEM, 3 WB.
- rf_write  out  1  RF write enable.
- rf_waddr  out  REG_ADDR_BITS  RF write address.
- rf_wdata  out  WORD_SIZE  RF write data.
- stall_cnt  out  CNT_BITS  saturating count of load-use stall cycles.

Behaviour:
- State: three slots EX, MEM, WB. Each slot holds: valid, wr, rd, load, data. EX holds no data; it uses ex_result.
- Reset (clk edge with reset=1): all slots invalid; stall_cnt=0.
- Outputs under reset: rf_write=0, stall=0, fwd_sel=0, opnd=rf_data.
- Reset overrides every other input, including mid-operation.
- Match on source n: slot.valid and slot.wr and slot.rd==issue_rsn and issue_usen.
- Forward priority, youngest first:
  - EX match and !EX.load: sel=1, opnd=ex_result.
  - else MEM match: sel=2, opnd=MEM.data.
  - else WB match: sel=3, opnd=WB.data.
  - else sel=0, opnd=rf_datan.
- Load-use: stall=1 when EX matches either source with EX.load=1 and issue_valid=1.
- stall is combinational and has no dependence on mem_busy or flush.
- Advance, when mem_busy=0:
  - WB <= MEM, with WB.data = MEM.load ? mem_rdata : MEM.data.
  - MEM <= EX, with MEM.data = ex_result (don't-care for loads).
  - EX <= issue fields with valid=1, only if issue_valid && !stall && !flush; otherwise EX becomes a bubble.
- flush && mem_busy=0: the current EX is not promoted (MEM becomes a bubble) and the new EX is a bubble.
- mem_busy=1: all slots hold.
- flush && mem_busy=1: EX.valid is cleared in place; MEM and WB hold.
- RF write port, combinational from WB: rf_write = WB.valid && WB.wr; rf_waddr = WB.rd; rf_wdata = WB.data.
- While frozen, rf_write stays asserted with the same values. The RF write is idempotent, so this is legal.
- stall_cnt increments by 1 each cycle with stall=1 and mem_busy=0. It saturates at all-ones and does not wrap.
- Latency: issue to rf_write asserted is 3 cycles. Forwarded values are visible the same cycle as ID.
- Register r0 is a normal register; there is no hardwired zero.
- The same rd in several slots is resolved by priority; the youngest wins.

Test Plan:
- Reset, then ADD r1 issued, followed by independent instructions -> cycle 3: rf_write=1, rf_waddr=1, rf_wdata=ex_result captured (0x1234). stall never asserted.
- Back-to-back ADD r2=0x00AA then read r2 -> fwd_sel1=1, opnd1=0x00AA. Same read one instruction later -> fwd_sel1=2; two later -> fwd_sel1=3; three later -> fwd_sel1=0, opnd1=rf_data1.
- LOAD r3 then immediate use of r3 -> stall=1 for 1 cycle, stall_cnt=1. Next cycle fwd_sel=2, opnd=mem_rdata (0xBEEF).
- r1 written in EX (0x1111) and in MEM (0x2222), ID reads r1 -> opnd1=0x1111, fwd_sel1=1.
- flush while EX holds a write to r2 -> no rf_write to r2 ever. Also with mem_busy=1 during the flush -> EX.valid cleared, MEM/WB outputs unchanged.
- Force 2^CNT_BITS+5 stall cycles -> stall_cnt=0xFFFF. Then reset high for one edge mid-stream -> all slots empty, rf_write=0, stall_cnt=0.
